// File: rtl/main_memory_ctrl_pkg.sv
// Shared encodings for the cache<->main-memory interface and the controller state machine.
package main_memory_ctrl_pkg;

    localparam logic [1:0] MEM_NOP        = 2'd0;
    localparam logic [1:0] MEM_READ       = 2'd1;
    localparam logic [1:0] MEM_READ_BURST = 2'd2;
    localparam logic [1:0] MEM_WRITE      = 2'd3;

    localparam logic [1:0] MEM_RESTING      = 2'd0;
    localparam logic [1:0] MEM_INST_WORKING = 2'd1;
    localparam logic [1:0] MEM_DATA_WORKING = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INST    = 2'd1,
        ST_DATA_RD = 2'd2,
        ST_DATA_WR = 2'd3
    } state_e;

    function automatic logic [1:0] status_of(input state_e s);
        case (s)
            ST_IDLE:    return MEM_RESTING;
            ST_INST:    return MEM_INST_WORKING;
            ST_DATA_RD: return MEM_DATA_WORKING;
            ST_DATA_WR: return MEM_DATA_WORKING;
            default:    return MEM_RESTING;
        endcase
    endfunction

endpackage

// File: rtl/main_memory_ctrl_mem_word_array.sv
// Single-port word RAM: one read or one write per cycle, registered read steered to the
// instruction or data output register.
module mem_word_array #(
    parameter int IW        = 15,
    parameter int LEN       = 32,
    parameter     INIT_FILE = ""
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           we,
    input  logic           dst_data,
    input  logic [IW-1:0]  addr,
    input  logic [LEN-1:0] wdata,
    output logic [LEN-1:0] inst_rdata,
    output logic [LEN-1:0] data_rdata
);

    logic [LEN-1:0] mem_q [0:(1<<IW)-1];
    logic [LEN-1:0] inst_rdata_q;
    logic [LEN-1:0] data_rdata_q;

    // Array write; suppressed while reset is asserted so an aborted burst never lands a word.
    always_ff @(posedge clk) begin
        if (en && we && rst_n) begin
            mem_q[addr] <= wdata;
        end
    end

    // Registered read into the requester-specific output register; the other one holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_rdata_q <= {LEN{1'b0}};
            data_rdata_q <= {LEN{1'b0}};
        end else if (en && !we) begin
            if (dst_data) begin
                data_rdata_q <= mem_q[addr];
            end else begin
                inst_rdata_q <= mem_q[addr];
            end
        end
    end

    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory responder serving i-cache single reads and d-cache read/write bursts.
// Define MEM_ERR_CHECK_EN to add the sticky mem_err output (misalignment / top-of-memory wrap).
module main_memory_ctrl
    import main_memory_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter     INIT_FILE        = ""
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_WIDTH-1:0]       inst_addr,
    input  logic [1:0]                  inst_vis_signal,
    output logic [LEN-1:0]              inst_data,
    input  logic [ADDR_WIDTH-1:0]       data_addr,
    input  logic [1:0]                  data_vis_signal,
    input  logic [LEN-1:0]              data_writen_data,
    input  logic [ENTRY_INDEX_SIZE-1:0] data_write_length,
    output logic [LEN-1:0]              mem_data,
`ifdef MEM_ERR_CHECK_EN
    output logic                        mem_err,
`endif
    output logic [1:0]                  mem_status
);

    localparam int IW = ADDR_WIDTH - 2;
    localparam int BW = $clog2(VECTOR_SIZE + 1);

    state_e         state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [IW-1:0]  base_q, base_d;
    logic [BW-1:0]  eff_len_q, eff_len_d;
    logic [1:0]     status_q, status_d;
    logic           err_q, err_d;

    logic           ram_en_s, ram_we_s, ram_dst_s;
    logic [IW-1:0]  ram_addr_s;
    logic [IW:0]    beat_sum_s;
    logic [BW-1:0]  req_len_s;
    logic           data_mis_s, inst_mis_s;

    // Carry out of base+beat marks a beat that wrapped past the top word.
    assign beat_sum_s = {1'b0, base_q} + (IW+1)'(beat_q);
    assign req_len_s  = (data_write_length == {ENTRY_INDEX_SIZE{1'b0}}) ?
                        BW'(VECTOR_SIZE) : BW'(data_write_length);
    assign data_mis_s = (data_addr[1:0] != 2'b00);
    assign inst_mis_s = (inst_addr[1:0] != 2'b00);

    // Next-state, beat bookkeeping and RAM port steering.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        base_d     = base_q;
        eff_len_d  = eff_len_q;
        err_d      = err_q;
        ram_en_s   = 1'b0;
        ram_we_s   = 1'b0;
        ram_dst_s  = 1'b0;
        ram_addr_s = beat_sum_s[IW-1:0];
        case (state_q)
            ST_IDLE: begin
                beat_d = {BW{1'b0}};
                if (data_vis_signal == MEM_READ_BURST) begin
                    base_d     = data_addr[ADDR_WIDTH-1:2];
                    ram_en_s   = 1'b1;
                    ram_dst_s  = 1'b1;
                    ram_addr_s = data_addr[ADDR_WIDTH-1:2];
                    beat_d     = BW'(1);
                    state_d    = ST_DATA_RD;
                    err_d      = err_q | data_mis_s;
                end else if (data_vis_signal == MEM_WRITE) begin
                    base_d     = data_addr[ADDR_WIDTH-1:2];
                    eff_len_d  = req_len_s;
                    ram_en_s   = 1'b1;
                    ram_we_s   = 1'b1;
                    ram_addr_s = data_addr[ADDR_WIDTH-1:2];
                    beat_d     = BW'(1);
                    state_d    = ST_DATA_WR;
                    err_d      = err_q | data_mis_s;
                end else if (data_vis_signal != MEM_NOP) begin
                    // Unsupported data opcode still claims the slot; the i-cache retries.
                    state_d = ST_IDLE;
                end else if (inst_vis_signal == MEM_READ) begin
                    ram_en_s   = 1'b1;
                    ram_addr_s = inst_addr[ADDR_WIDTH-1:2];
                    state_d    = ST_INST;
                    err_d      = err_q | inst_mis_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INST: begin
                state_d = ST_IDLE;
            end
            ST_DATA_RD: begin
                if ((data_vis_signal == MEM_READ_BURST) && (beat_q < BW'(VECTOR_SIZE))) begin
                    ram_en_s  = 1'b1;
                    ram_dst_s = 1'b1;
                    beat_d    = beat_q + BW'(1);
                    err_d     = err_q | beat_sum_s[IW];
                end else begin
                    beat_d  = {BW{1'b0}};
                    state_d = ST_IDLE;
                end
            end
            ST_DATA_WR: begin
                if ((data_vis_signal == MEM_WRITE) && (beat_q < BW'(VECTOR_SIZE))) begin
                    if (beat_q < eff_len_q) begin
                        ram_en_s = 1'b1;
                        ram_we_s = 1'b1;
                        err_d    = err_q | beat_sum_s[IW];
                    end else begin
                        ram_en_s = 1'b0;
                    end
                    beat_d = beat_q + BW'(1);
                end else begin
                    beat_d  = {BW{1'b0}};
                    state_d = ST_IDLE;
                end
            end
            default: begin
                beat_d  = {BW{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
        status_d = status_of(state_d);
    end

    // Controller state and registered status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            beat_q    <= {BW{1'b0}};
            base_q    <= {IW{1'b0}};
            eff_len_q <= {BW{1'b0}};
            status_q  <= MEM_RESTING;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            eff_len_q <= eff_len_d;
            status_q  <= status_d;
            err_q     <= err_d;
        end
    end

    mem_word_array #(
        .IW        (IW),
        .LEN       (LEN),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (ram_en_s),
        .we         (ram_we_s),
        .dst_data   (ram_dst_s),
        .addr       (ram_addr_s),
        .wdata      (data_writen_data),
        .inst_rdata (inst_data),
        .data_rdata (mem_data)
    );

    assign mem_status = status_q;

`ifdef MEM_ERR_CHECK_EN
    assign mem_err = err_q;
`else
    logic unused_err_s;
    assign unused_err_s = err_q;
`endif

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed self-checking bench for main_memory_ctrl; mem_err checks are active when MEM_ERR_CHECK_EN is defined.
module tb_main_memory_ctrl;

    localparam logic [1:0] NOP = 2'd0, RD = 2'd1, RDB = 2'd2, WR = 2'd3;
    localparam logic [1:0] ST_REST = 2'd0, ST_INSTW = 2'd1, ST_DATAW = 2'd2;

    logic        clk;
    logic        rst_n;
    logic [16:0] inst_addr;
    logic [1:0]  inst_vis_signal;
    logic [31:0] inst_data;
    logic [16:0] data_addr;
    logic [1:0]  data_vis_signal;
    logic [31:0] data_writen_data;
    logic [2:0]  data_write_length;
    logic [31:0] mem_data;
    logic [1:0]  mem_status;
`ifdef MEM_ERR_CHECK_EN
    logic        mem_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_beats [8];

    main_memory_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .inst_addr         (inst_addr),
        .inst_vis_signal   (inst_vis_signal),
        .inst_data         (inst_data),
        .data_addr         (data_addr),
        .data_vis_signal   (data_vis_signal),
        .data_writen_data  (data_writen_data),
        .data_write_length (data_write_length),
        .mem_data          (mem_data),
`ifdef MEM_ERR_CHECK_EN
        .mem_err           (mem_err),
`endif
        .mem_status        (mem_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [16:0] a, input logic [2:0] len, input logic [31:0] v0);
        data_vis_signal   = WR;
        data_addr         = a;
        data_write_length = len;
        for (int i = 0; i < 8; i++) begin
            data_writen_data = v0 + 32'(i);
            tick();
            check_val("wr_status", 32'(mem_status), 32'(ST_DATAW));
        end
        data_vis_signal = NOP;
        tick();
        check_val("wr_done_status", 32'(mem_status), 32'(ST_REST));
    endtask

    task automatic rd_burst(input logic [16:0] a, input int n);
        data_vis_signal = RDB;
        data_addr       = a;
        for (int i = 0; i < n; i++) begin
            tick();
            check_val($sformatf("rd_beat%0d", i), mem_data, exp_beats[i]);
            check_val("rd_status", 32'(mem_status), 32'(ST_DATAW));
        end
        data_vis_signal = NOP;
        tick();
        check_val("rd_done_status", 32'(mem_status), 32'(ST_REST));
    endtask

    initial begin
        rst_n = 1'b0;
        inst_addr = 17'h0; inst_vis_signal = NOP;
        data_addr = 17'h0; data_vis_signal = NOP;
        data_writen_data = 32'h0; data_write_length = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_status", 32'(mem_status), 32'(ST_REST));
        check_val("rst_mem_data", mem_data, 32'h0);
        check_val("rst_inst_data", inst_data, 32'h0);
`ifdef MEM_ERR_CHECK_EN
        check_val("rst_err", 32'(mem_err), 32'h0);
`endif
        tick();

        // Full burst write then read back 1..8
        wr_burst(17'h100, 3'd0, 32'd1);
        for (int i = 0; i < 8; i++) exp_beats[i] = 32'(i + 1);
        rd_burst(17'h100, 8);

        // len=3 write over a prefilled region
        wr_burst(17'h200, 3'd0, 32'h50);
        wr_burst(17'h200, 3'd3, 32'hA0);
        exp_beats = '{32'hA0, 32'hA1, 32'hA2, 32'h53, 32'h54, 32'h55, 32'h56, 32'h57};
        rd_burst(17'h200, 8);

        wr_burst(17'h040, 3'd1, 32'hDEADBEEF);

        // Misaligned inst read 0x102 -> word 0x40 (byte 0x100) = 1
        inst_vis_signal = RD; inst_addr = 17'h102;
        tick();
        check_val("inst_mis_data", inst_data, 32'd1);
        check_val("inst_status", 32'(mem_status), 32'(ST_INSTW));
`ifdef MEM_ERR_CHECK_EN
        check_val("err_misaligned", 32'(mem_err), 32'h1);
`endif
        inst_vis_signal = NOP;
        tick();
        check_val("inst_done_status", 32'(mem_status), 32'(ST_REST));

        // Arbitration: data wins, inst ignored then retried
        inst_vis_signal = RD; inst_addr = 17'h040;
        data_vis_signal = RDB; data_addr = 17'h100;
        tick();
        check_val("arb_status", 32'(mem_status), 32'(ST_DATAW));
        check_val("arb_inst_hold", inst_data, 32'd1);
        check_val("arb_mem_data", mem_data, 32'd1);
        data_vis_signal = NOP;
        tick();
        check_val("arb_idle", 32'(mem_status), 32'(ST_REST));
        check_val("arb_inst_hold2", inst_data, 32'd1);
        tick();
        check_val("arb_retry_data", inst_data, 32'hDEADBEEF);
        check_val("arb_retry_status", 32'(mem_status), 32'(ST_INSTW));
        inst_vis_signal = NOP;
        tick();

        // Early abort after 2 beats, then a fresh burst starts at beat 0
        exp_beats[0] = 32'd1; exp_beats[1] = 32'd2;
        rd_burst(17'h100, 2);
        check_val("abort_hold", mem_data, 32'd2);
        exp_beats[0] = 32'hA0;
        rd_burst(17'h200, 1);

        // Reset in the middle of a read burst
        data_vis_signal = RDB; data_addr = 17'h100;
        repeat (3) tick();
        check_val("pre_rst_beat3", mem_data, 32'd3);
        rst_n = 1'b0;
        #1;
        check_val("midrst_status", 32'(mem_status), 32'(ST_REST));
        check_val("midrst_mem_data", mem_data, 32'h0);
        data_vis_signal = NOP;
        #1;
        rst_n = 1'b1;
        inst_vis_signal = RD; inst_addr = 17'h104;
        tick();
        check_val("post_rst_inst", inst_data, 32'd2);
`ifdef MEM_ERR_CHECK_EN
        check_val("post_rst_err", 32'(mem_err), 32'h0);
`endif
        inst_vis_signal = NOP;
        tick();

        // Wrap at top of memory: beat 1 lands in word 0
        wr_burst(17'h1FFFC, 3'd2, 32'h77);
`ifdef MEM_ERR_CHECK_EN
        check_val("err_wrap", 32'(mem_err), 32'h1);
`endif
        inst_vis_signal = RD; inst_addr = 17'h0;
        tick();
        check_val("wrap_word0", inst_data, 32'h78);
        inst_vis_signal = NOP;
        tick();
        exp_beats[0] = 32'h77; exp_beats[1] = 32'h78;
        rd_burst(17'h1FFFC, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
